perceptron_host_driver: RTL

Host-side driver for the perceptron core's pin protocol. It buffers one frame of weights, inputs and bias written by a local controller, then streams the frame onto the core's dedicated-input and bidirectional pins, fires the evaluation, and captures the result byte from the core's dedicated outputs. It sits on the bring-up/FPGA side of the chip boundary and drives the protocol the core receives.

---
 rtl/perceptron_host_driver_if.sv | 31 +++
 rtl/perceptron_host_driver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/perceptron_host_driver_if.sv
// Bus bundle for perceptron_host_driver: local controller side plus core pin side.
// The slave modport is the driver; the master modport is the controller/core model.
interface perceptron_host_driver_if #(
  parameter int unsigned N_INPUTS = 4
);
  localparam int unsigned AW = $clog2(2 * N_INPUTS + 1);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start;
  logic          busy;
  logic [7:0]    result;
  logic          result_valid;
  logic          timeout_err;
  logic [7:0]    pin_data;
  logic [1:0]    pin_type;
  logic          pin_strobe;
  logic [7:0]    pin_result;
  logic          pin_done;

  modport slave (
    input  wr_en, wr_addr, wr_data, start, pin_result, pin_done,
    output busy, result, result_valid, timeout_err, pin_data, pin_type, pin_strobe
  );

  modport master (
    output wr_en, wr_addr, wr_data, start, pin_result, pin_done,
    input  busy, result, result_valid, timeout_err, pin_data, pin_type, pin_strobe
  );
endinterface

// File: rtl/perceptron_host_driver.sv
// Host-side driver for the perceptron core pin protocol: buffers one frame
// (weights, inputs, bias), streams it strobe/gap onto the core pins, fires
// the evaluation and captures the result byte.
// Optional feature macro: PERCEPTRON_DRV_RETRY_EN (one silent resend on first timeout).
module perceptron_host_driver #(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input logic                     clk,
  input logic                     rst,
  perceptron_host_driver_if.slave bus
);
  localparam int unsigned NBYTES = 2 * N_INPUTS + 1;
  localparam int unsigned AW     = $clog2(NBYTES);
  localparam int unsigned CW     = 16;

  localparam logic [AW-1:0] LAST_IDX = AW'(2 * N_INPUTS);
  localparam logic [AW-1:0] N_IDX    = AW'(N_INPUTS);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEND_STB = 3'd1;
  localparam logic [2:0] S_SEND_GAP = 3'd2;
  localparam logic [2:0] S_FIRE_STB = 3'd3;
  localparam logic [2:0] S_FIRE_GAP = 3'd4;
  localparam logic [2:0] S_WAIT     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [7:0]    frame_mem [NBYTES];
  logic [2:0]    state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
`ifdef PERCEPTRON_DRV_RETRY_EN
  logic          retried, retried_nxt;
`endif

  logic       busy_q, busy_nxt;
  logic [7:0] result_q, result_nxt;
  logic       result_valid_q, result_valid_nxt;
  logic       timeout_err_q, timeout_err_nxt;
  logic [7:0] pin_data_q, pin_data_nxt;
  logic [1:0] pin_type_q, pin_type_nxt;
  logic       pin_strobe_q, pin_strobe_nxt;

  logic       wr_accept_c;
  logic [7:0] send_byte_c;

  assign wr_accept_c = bus.wr_en && (state == S_IDLE) && (bus.wr_addr <= LAST_IDX);

  // Same-cycle write forwarding so a write accepted with start is what gets sent
  assign send_byte_c = (wr_accept_c && (bus.wr_addr == idx_nxt)) ? bus.wr_data
                                                                 : frame_mem[idx_nxt];

  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.pin_data     = pin_data_q;
  assign bus.pin_type     = pin_type_q;
  assign bus.pin_strobe   = pin_strobe_q;

  // Frame buffer: cleared on reset, written only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NBYTES; i++) frame_mem[i] <= 8'h00;
    end else if (wr_accept_c) begin
      frame_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      cnt            <= '0;
`ifdef PERCEPTRON_DRV_RETRY_EN
      retried        <= 1'b0;
`endif
      busy_q         <= 1'b0;
      result_q       <= 8'h00;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      pin_data_q     <= 8'h00;
      pin_type_q     <= 2'b00;
      pin_strobe_q   <= 1'b0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      cnt            <= cnt_nxt;
`ifdef PERCEPTRON_DRV_RETRY_EN
      retried        <= retried_nxt;
`endif
      busy_q         <= busy_nxt;
      result_q       <= result_nxt;
      result_valid_q <= result_valid_nxt;
      timeout_err_q  <= timeout_err_nxt;
      pin_data_q     <= pin_data_nxt;
      pin_type_q     <= pin_type_nxt;
      pin_strobe_q   <= pin_strobe_nxt;
    end
  end

  // Next state, then outputs for the upcoming cycle derived from the next state
  always_comb begin
    state_nxt        = state;
    idx_nxt          = idx;
    cnt_nxt          = cnt;
`ifdef PERCEPTRON_DRV_RETRY_EN
    retried_nxt      = retried;
`endif
    result_nxt       = result_q;
    timeout_err_nxt  = timeout_err_q;
    pin_data_nxt     = pin_data_q;
    pin_type_nxt     = pin_type_q;
    pin_strobe_nxt   = 1'b0;
    result_valid_nxt = 1'b0;
    busy_nxt         = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt       = S_SEND_STB;
          idx_nxt         = '0;
          timeout_err_nxt = 1'b0;
`ifdef PERCEPTRON_DRV_RETRY_EN
          retried_nxt     = 1'b0;
`endif
        end
      end
      S_SEND_STB: state_nxt = S_SEND_GAP;
      S_SEND_GAP: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_FIRE_STB;
        end else begin
          idx_nxt   = idx + AW'(1);
          state_nxt = S_SEND_STB;
        end
      end
      S_FIRE_STB: state_nxt = S_FIRE_GAP;
      S_FIRE_GAP: begin
        state_nxt = S_WAIT;
        cnt_nxt   = '0;
      end
      S_WAIT: begin
        if (bus.pin_done) begin
          result_nxt = bus.pin_result;
          state_nxt  = S_DONE;
        end else if ((cnt + CW'(1)) == TO_LIMIT) begin
`ifdef PERCEPTRON_DRV_RETRY_EN
          if (!retried) begin
            retried_nxt = 1'b1;
            idx_nxt     = '0;
            state_nxt   = S_SEND_STB;
          end else begin
            timeout_err_nxt = 1'b1;
            state_nxt       = S_IDLE;
          end
`else
          timeout_err_nxt = 1'b1;
          state_nxt       = S_IDLE;
`endif
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt         = (state_nxt != S_IDLE);
    result_valid_nxt = (state_nxt == S_DONE);

    if (state_nxt == S_SEND_STB) begin
      pin_strobe_nxt = 1'b1;
      pin_data_nxt   = send_byte_c;
      if (idx_nxt < N_IDX)         pin_type_nxt = 2'b00;
      else if (idx_nxt < LAST_IDX) pin_type_nxt = 2'b01;
      else                         pin_type_nxt = 2'b10;
    end else if (state_nxt == S_FIRE_STB) begin
      pin_strobe_nxt = 1'b1;
      pin_data_nxt   = 8'h00;
      pin_type_nxt   = 2'b11;
    end
  end
endmodule
